// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one shared round datapath reused for
// rounds 1..9, a final round without MixColumns, and on-the-fly key expansion.
module aes128_iter_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic [3:0]   round_idx
);

   generate
      if (ROUNDS != 10) begin : g_rounds_check
         $error("aes128_iter_ctrl supports ROUNDS = 10 (AES-128) only");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_LAST  = 2'd2,
      S_DONE  = 2'd3
   } fsm_e;

   localparam logic [3:0] LAST_RND = 4'(ROUNDS);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry b sits at bit offset 2047 - 8*b, i.e. {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte n of the state is row n%4 of column n/4; ShiftRows pulls row r from column c+r.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w3, w4, w5, w6, w7;
      w3 = rk[31:0];
      w4 = rk[127:96] ^ {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rc, 24'h0};
      w5 = rk[95:64] ^ w4;
      w6 = rk[63:32] ^ w5;
      w7 = w3 ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   fsm_e         fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] ct_q, ct_d;

   logic [127:0] rk_next, ss, full_rnd, last_rnd;
   logic         accept;

   always_comb begin
      rk_next  = expand(rk_q, rcon(rnd_q));
      ss       = sub_shift(blk_q);
      full_rnd = mix_columns(ss) ^ rk_next;
      last_rnd = ss ^ rk_next;
   end

   assign in_ready   = !rst && (fsm_q == S_IDLE || (fsm_q == S_DONE && out_ready));
   assign accept     = in_valid && in_ready;
   assign out_valid  = (fsm_q == S_DONE);
   assign busy       = (fsm_q == S_ROUND) || (fsm_q == S_LAST);
   assign round_idx  = busy ? rnd_q : 4'd0;
   assign ciphertext = ct_q;

   always_comb begin
      // NOTE: every target gets a hold value first so no path leaves it unassigned (no latches).
      fsm_d = fsm_q;
      blk_d = blk_q;
      rk_d  = rk_q;
      rnd_d = rnd_q;
      ct_d  = ct_q;
      case (fsm_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               blk_d = plaintext ^ key;
               rk_d  = key;
               rnd_d = 4'd1;
               fsm_d = S_ROUND;
            end else if (fsm_q == S_DONE && out_ready) begin
               fsm_d = S_IDLE;
            end
         end
         S_ROUND: begin
            blk_d = full_rnd;
            rk_d  = rk_next;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_RND - 4'd1) fsm_d = S_LAST;
         end
         S_LAST: begin
            ct_d  = last_rnd;
            rk_d  = rk_next;
            rnd_d = 4'd0;
            fsm_d = S_DONE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         fsm_q <= S_IDLE;
         blk_q <= '0;
         rk_q  <= '0;
         rnd_q <= '0;
         ct_q  <= '0;
      end else begin
         fsm_q <= fsm_d;
         blk_q <= blk_d;
         rk_q  <= rk_d;
         rnd_q <= rnd_d;
         ct_q  <= ct_d;
      end
   end

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption engine controller.
- Accepts one plaintext/key pair through a valid/ready handshake and applies the initial AddRoundKey on acceptance.
- Sequences one shared full-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) for rounds 1–9, then the final-round datapath (no MixColumns) for round 10, expanding round keys on the fly.
- Sits between the host/DMA interface and the ciphertext sink.

Parameters:
- ROUNDS, 10, round count. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext and key are valid.
- in_ready  output  1  block can accept a new job.
- plaintext  input  128  block in FIPS-197 byte order: byte0 = [127:120], column0 = [127:96].
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  sink accepts ciphertext.
- ciphertext  output  128  result, same byte order.
- busy  output  1  high in ROUND and LAST states.
- round_idx  output  4  current round number (1..10); 0 when not running.

Behaviour:
- Reset: one clk edge with rst=1 forces state IDLE. The state register, round-key register, round counter and ciphertext register all clear to 0. out_valid=0, busy=0, round_idx=0. in_ready=0 while rst=1.
- Reset mid-job aborts it; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: state_reg <= plaintext^key; rk_reg <= key; round_cnt <= 1; go to ROUND.
  - ROUND (round_cnt 1..9): rk_next = expand(rk_reg, rcon[round_cnt]). state_reg <= full_round(state_reg, rk_next). rk_reg <= rk_next. round_cnt++. Go to LAST when round_cnt==9.
  - LAST (round_cnt==10): rk_next = expand(rk_reg, 0x36). ciphertext reg <= last_round(state_reg, rk_next). out_valid <= 1. Go to DONE.
  - DONE: out_valid=1; ciphertext held stable while out_ready=0.
    - out_ready=1 and in_valid=0: out_valid <= 0; go to IDLE.
    - out_ready=1 and in_valid=1: back-to-back. in_ready=1 (in_ready = IDLE || (DONE && out_ready)); the new job is loaded exactly as from IDLE and the state goes to ROUND. out_valid drops the next cycle.
- Latency: job accepted at edge T; out_valid rises at edge T+10. Ten clk cycles are spent in ROUND/LAST.
- Maximum throughput: one block per 11 cycles with out_ready tied high.
- Key expansion: w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6. Words are rk[127:96]..rk[31:0].
  - Rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - Key expansion uses 4 S-box lookups, independent of the datapath S-boxes.
- in_valid while busy is ignored, because in_ready=0; plaintext and key are not sampled.
- Input data need only be stable in the acceptance cycle.
- round_idx = round_cnt in ROUND/LAST, 0 otherwise. busy=1 exactly in ROUND/LAST.
- Every output is registered or decoded from state only. in_ready additionally depends combinationally on out_ready, in DONE only.
- No X propagation: registers are loaded only on the defined transitions above.

Test Plan:
- FIPS-197 C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, accepted at edge T → out_valid rises at T+10; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; busy high for 10 cycles; round_idx steps 1..10.
- FIPS-197 App. B: 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → 3925841d02dc09fbdc118597196a0b32. Check the internal round-10 key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: out_ready=0 for 20 cycles after completion → out_valid stays 1, ciphertext constant, in_ready=0. Raise out_ready with in_valid=0 → out_valid=0 next cycle, in_ready=1.
- Back-to-back: two jobs (C.1 then App. B), in_valid held high, out_ready=1 → second job accepted in the same cycle the first result is consumed; results arrive 11 cycles apart in order.
- Ignored input: in_valid pulsed with a different plaintext at round 5 → no acceptance, result still 69c4e0d8…c55a.
- Reset mid-job: rst=1 for one cycle at round 6 → next cycle: out_valid=0, busy=0, round_idx=0, in_ready=1. A fresh C.1 job then produces the correct ciphertext with 10-cycle latency.
